fb_scanout: RTL

- Read-side client of the SPRAM framebuffer (320x240, 8-bit pixels, 17-bit address, 2-cycle read latency from address to registered read data).
- Sweeps one full frame per start pulse and streams pixels in raster order to the LCD driver over a valid/ready interface.
- Applies a waterfall row offset: displayed row 0 is framebuffer row row_base, wrapping at HEIGHT.
- Never writes memory; the top ties the framebuffer write enable to the writer side.

---
 rtl/fb_scanout.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: sweeps one framebuffer frame per start pulse and streams pixels over valid/ready.
// Defining SCANOUT_MIRROR_EN adds the mirror port, which reads each line from the right edge to the left.
module fb_scanout #(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        row_base,
`ifdef SCANOUT_MIRROR_EN
  input  logic              mirror,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_eof
);
  localparam int DEPTH = READ_LAT + 2;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] COL_L = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_L = RW'(HEIGHT - 1);
  localparam logic [PW-1:0] PTR_L = PW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(WIDTH * HEIGHT);
  typedef enum logic [1:0] {IDLE, SETUP, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [7:0] base;
  logic [ADDR_W-1:0] line_ptr;
  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row;
  // stage 0 is aligned with mem_addr; the next READ_LAT stages follow the read through the memory
  logic [READ_LAT:0] trk_v, trk_eol, trk_eof;
  logic [DATA_W+1:0] fifo [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ, inflight;
  logic issue, push, pop, last_col, last_pix;
`ifdef SCANOUT_MIRROR_EN
  logic mir;
  // mirror is a per-frame setting, captured with the start that opens the frame
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mir <= 1'b0;
    else if (state == IDLE && start) mir <= mirror;
  assign col_eff = mir ? COL_L - col : col;
`else
  assign col_eff = col;
`endif
  // count reads still travelling toward the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= READ_LAT; i++) inflight = inflight + OW'(trk_v[i]);
  end
  assign pix_valid = occ != '0;
  assign {pix_eof, pix_eol, pix_data} = pix_valid ? fifo[rd_ptr] : '0;
  assign pop = pix_valid && pix_ready;
  assign push = trk_v[READ_LAT];
  assign last_col = col == COL_L;
  assign last_pix = last_col && row == ROW_L;
  // a slot is reserved for every read in flight, so the FIFO cannot overflow whatever the stalls
  assign issue = state == RUN && int'(occ) + int'(inflight) - int'(pop) < DEPTH;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // one frame per accepted start; DRAIN ends when the eof pixel is taken downstream
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SETUP : IDLE;
      SETUP:   state_nx = RUN;
      RUN:     state_nx = issue && last_pix ? DRAIN : RUN;
      DRAIN:   state_nx = pop && pix_eof ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // address generation with the waterfall wrap, plus the in-flight tag pipeline
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      base <= '0;
      line_ptr <= '0;
      col <= '0;
      row <= '0;
      mem_addr <= '0;
      trk_v <= '0;
      trk_eol <= '0;
      trk_eof <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == DRAIN && pop && pix_eof;
      trk_v <= {trk_v[READ_LAT-1:0], issue};
      trk_eol <= {trk_eol[READ_LAT-1:0], issue && last_col};
      trk_eof <= {trk_eof[READ_LAT-1:0], issue && last_pix};
      if (state == IDLE && start) base <= 32'(row_base) >= HEIGHT ? '0 : row_base;
      if (state == SETUP) begin
        line_ptr <= ADDR_W'(int'(base) * WIDTH);
        col <= '0;
        row <= '0;
      end
      if (issue) begin
        mem_addr <= line_ptr + ADDR_W'(col_eff);
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) begin
          line_ptr <= (line_ptr + W_A) == FRAME ? '0 : line_ptr + W_A;
          row <= row + RW'(1);
        end
      end
    end
  // FIFO storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {trk_eof[READ_LAT], trk_eol[READ_LAT], mem_r_data};
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PTR_L ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PTR_L ? '0 : rd_ptr + PW'(1);
      occ <= occ + OW'(push) - OW'(pop);
    end
endmodule
